// File: rtl/dmem_lsu.sv
// Load/store unit between the core datapath and a word-organised data memory.
//
// Takes one byte-addressed load or store at a time and talks to dmem with whole-word
// accesses only. Sub-word stores are done as read-modify-write, and loads are extracted
// and sign/zero-extended here. Each request ends with a single-cycle o_done pulse.
//
// Optional feature macro: LSU_MISALIGN_EN
//   defined   - misaligned accesses are executed; a word-crossing access also touches
//               word A+1 (through RD1/WR1), and o_misaligned never asserts.
//   undefined - misaligned H/HU/SH/W/SW accesses are rejected: no memory access,
//               o_rdata = 0, o_misaligned = 1.
//
// Ports
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_req / o_ready      request handshake (o_ready is high only in IDLE)
//   i_we, i_funct3       store/load select, access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   i_addr, i_wdata      byte address (bits above ADDR_W are ignored), store data
//   o_done               one-cycle completion pulse
//   o_rdata              load result, held until the next completion
//   o_misaligned         pulses with o_done on a rejected misaligned access
//   o_mem_addr           dmem word address
//   o_mem_wdata          dmem write word
//   o_mem_wren           dmem write enable
//   o_mem_funct3         dmem access size, always word
//   i_mem_q              dmem combinational read word
module dmem_lsu #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic              o_misaligned,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_wren,
  output logic [2:0]        o_mem_funct3,
  input  logic [31:0]       i_mem_q
);

  localparam int unsigned WordW = ADDR_W - 2;

  typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StDone} state_e;

  state_e             state_q, state_d;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rd_lo_q, rd_hi_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               misal_q, misal_d;

  logic               unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_W];

  // In IDLE the decode looks at the live request; in every other state at the captured one.
  logic               is_idle;
  logic               cur_we;
  logic [2:0]         cur_f3;
  logic [1:0]         cur_off;
  assign is_idle = (state_q == StIdle);
  assign cur_we  = is_idle ? i_we : we_q;
  assign cur_f3  = is_idle ? i_funct3 : funct3_q;
  assign cur_off = is_idle ? i_addr[1:0] : addr_q[1:0];

  logic       valid;
  logic       reject;
  logic       crossing;
  logic       misal_flag;
  logic       full_word;
  logic [3:0] size_mask;

  always_comb begin
    if (cur_we) valid = ~cur_f3[2] & (cur_f3[1:0] != 2'b11);
    else        valid = (cur_f3[1:0] != 2'b11) & ~(cur_f3[2] & cur_f3[1]);
  end

  assign full_word = (cur_f3[1:0] == 2'b10);

  always_comb begin
    size_mask = 4'b1111;
    case (cur_f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

`ifdef LSU_MISALIGN_EN
  logic [2:0] size_b;
  always_comb begin
    size_b = 3'd4;
    case (cur_f3[1:0])
      2'b00:   size_b = 3'd1;
      2'b01:   size_b = 3'd2;
      default: size_b = 3'd4;
    endcase
  end
  assign crossing   = ({1'b0, cur_off} + size_b) > 3'd4;
  assign reject     = ~valid;
  assign misal_flag = 1'b0;
`else
  logic misal_raw;
  assign misal_raw  = ((cur_f3[1:0] == 2'b01) & cur_off[0]) |
                      ((cur_f3[1:0] == 2'b10) & (cur_off != 2'b00));
  assign crossing   = 1'b0;
  assign reject     = ~valid | misal_raw;
  assign misal_flag = valid & misal_raw;
`endif

  // Both words are viewed as one 64-bit little-endian window starting at word A.
  logic [4:0]  sh;
  logic [63:0] rd64;
  logic [63:0] wr64;
  logic [7:0]  mask8;
  logic [63:0] merged;
  assign sh    = {cur_off, 3'b000};
  assign rd64  = {rd_hi_q, rd_lo_q};
  assign wr64  = {32'b0, wdata_q} << sh;
  assign mask8 = {4'b0000, size_mask} << cur_off;

  always_comb begin
    merged = rd64;
    for (int i = 0; i < 8; i++) begin
      if (mask8[i]) merged[8*i +: 8] = wr64[8*i +: 8];
    end
  end

  // Load result, formed on the edge that leaves the last read state.
  logic [31:0] lo_src, hi_src;
  logic [31:0] ld_word;
  logic [31:0] ld_result;
  assign lo_src  = (state_q == StRd1) ? rd_lo_q : i_mem_q;
  assign hi_src  = (state_q == StRd1) ? i_mem_q : rd_hi_q;
  assign ld_word = 32'({hi_src, lo_src} >> sh);

  always_comb begin
    ld_result = ld_word;
    case (funct3_q)
      3'b000:  ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_result = {24'b0, ld_word[7:0]};
      3'b101:  ld_result = {16'b0, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    misal_d = misal_q;
    unique case (state_q)
      StIdle: begin
        if (i_req) begin
          if (reject) begin
            state_d = StDone;
            rdata_d = '0;
            misal_d = misal_flag;
          end else if (i_we && full_word && (i_addr[1:0] == 2'b00)) begin
            state_d = StWr0;
          end else begin
            state_d = StRd0;
          end
        end
      end
      StRd0: begin
        if (crossing) begin
          state_d = StRd1;
        end else if (we_q) begin
          state_d = StWr0;
        end else begin
          state_d = StDone;
          rdata_d = ld_result;
          misal_d = 1'b0;
        end
      end
      StRd1: begin
        if (we_q) begin
          state_d = StWr0;
        end else begin
          state_d = StDone;
          rdata_d = ld_result;
          misal_d = 1'b0;
        end
      end
      StWr0: begin
        if (crossing) begin
          state_d = StWr1;
        end else begin
          state_d = StDone;
          rdata_d = '0;
          misal_d = 1'b0;
        end
      end
      StWr1: begin
        state_d = StDone;
        rdata_d = '0;
        misal_d = 1'b0;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_lo_q  <= '0;
      rd_hi_q  <= '0;
      rdata_q  <= '0;
      misal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
      if (is_idle && i_req) begin
        we_q     <= i_we;
        funct3_q <= i_funct3;
        addr_q   <= i_addr[ADDR_W-1:0];
        wdata_q  <= i_wdata;
      end
      if (state_q == StRd0) rd_lo_q <= i_mem_q;
      if (state_q == StRd1) rd_hi_q <= i_mem_q;
    end
  end

  // Word A+1 wraps naturally at the top of the word address space.
  logic [WordW-1:0] word_a, word_b;
  assign word_a = addr_q[ADDR_W-1:2];
  assign word_b = word_a + WordW'(1);

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    unique case (state_q)
      StRd0: o_mem_addr = word_a;
      StRd1: o_mem_addr = word_b;
      StWr0: begin
        o_mem_addr  = word_a;
        o_mem_wdata = merged[31:0];
      end
      StWr1: begin
        o_mem_addr  = word_b;
        o_mem_wdata = merged[63:32];
      end
      default: ;
    endcase
  end

  // Gated by reset so a write can never land on an edge where reset is sampled.
  assign o_mem_wren   = ((state_q == StWr0) || (state_q == StWr1)) && i_rst_n;
  assign o_mem_funct3 = 3'b010;
  assign o_ready      = is_idle;
  assign o_done       = (state_q == StDone);
  assign o_rdata      = rdata_q;
  assign o_misaligned = misal_q && (state_q == StDone);

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req;
  logic        o_ready;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_misaligned;
  logic [8:0]  o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_wren;
  logic [2:0]  o_mem_funct3;
  logic [31:0] i_mem_q;

  dmem_lsu #(.ADDR_W(11)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req       (i_req),
    .o_ready     (o_ready),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_misaligned(o_misaligned),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_wren  (o_mem_wren),
    .o_mem_funct3(o_mem_funct3),
    .i_mem_q     (i_mem_q)
  );

  always #5 i_clk = ~i_clk;

  // dmem model: combinational read, write on the rising edge.
  logic [31:0] mem [512];
  int          wr_cnt = 0;
  assign i_mem_q = mem[o_mem_addr];
  always @(posedge i_clk) begin
    if (o_mem_wren) begin
      mem[o_mem_addr] <= o_mem_wdata;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  localparam logic       ST = 1'b1;
  localparam logic       LD = 1'b0;
  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          nwr;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic chk_rd,
                              input logic [31:0] rd, input logic mis, input int lat,
                              input int nwr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.chk_rd = chk_rd;
    v.rd = rd; v.mis = mis; v.lat = lat; v.nwr = nwr;
    return v;
  endfunction

  // Issue one request and wait (bounded) for its completion pulse.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic mis,
                        output int lat, output int nwr);
    int   start;
    logic got;
    @(negedge i_clk);
    chk("ready_before_req", {31'b0, o_ready}, 32'd1);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    start = wr_cnt;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      lat++;
      if (o_done) got = 1'b1;
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    rd  = o_rdata;
    mis = o_misaligned;
    nwr = wr_cnt - start;
  endtask

  vec_t vt [28];

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat, nwr, start, blat;
    logic        got;

    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000;
    i_addr = '0; i_wdata = '0;

    vt[0]  = mk(ST, FW,  32'h010, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 2, 1);
    vt[1]  = mk(LD, FW,  32'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 0);
    vt[2]  = mk(ST, FW,  32'h020, 32'h11223344, 1'b0, 32'h0,        1'b0, 2, 1);
    vt[3]  = mk(ST, FB,  32'h021, 32'h123456AA, 1'b0, 32'h0,        1'b0, 3, 1);
    vt[4]  = mk(LD, FW,  32'h020, 32'h0,        1'b1, 32'h1122AA44, 1'b0, 2, 0);
    vt[5]  = mk(LD, FB,  32'h021, 32'h0,        1'b1, 32'hFFFFFFAA, 1'b0, 2, 0);
    vt[6]  = mk(LD, FBU, 32'h021, 32'h0,        1'b1, 32'h000000AA, 1'b0, 2, 0);
    vt[7]  = mk(ST, FW,  32'h030, 32'h55667788, 1'b0, 32'h0,        1'b0, 2, 1);
    vt[8]  = mk(ST, FH,  32'h032, 32'hABCD8001, 1'b0, 32'h0,        1'b0, 3, 1);
    vt[9]  = mk(LD, FH,  32'h032, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 2, 0);
    vt[10] = mk(LD, FHU, 32'h032, 32'h0,        1'b1, 32'h00008001, 1'b0, 2, 0);
    vt[11] = mk(LD, FW,  32'h030, 32'h0,        1'b1, 32'h80017788, 1'b0, 2, 0);
`ifdef LSU_MISALIGN_EN
    vt[12] = mk(LD, FH,  32'h031, 32'h0,        1'b1, 32'h00000177, 1'b0, 2, 0);
`else
    vt[12] = mk(LD, FH,  32'h031, 32'h0,        1'b1, 32'h0,        1'b1, 1, 0);
`endif
    vt[13] = mk(LD, 3'b011, 32'h010, 32'h0,      1'b1, 32'h0,        1'b0, 1, 0);
    vt[14] = mk(ST, 3'b100, 32'h010, 32'h0,      1'b1, 32'h0,        1'b0, 1, 0);
    vt[15] = mk(ST, 3'b011, 32'h010, 32'h01020304, 1'b1, 32'h0,      1'b0, 1, 0);
    vt[16] = mk(LD, FW,  32'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2, 0);
    vt[17] = mk(ST, FB,  32'h013, 32'h0000007F, 1'b0, 32'h0,        1'b0, 3, 1);
    vt[18] = mk(LD, FB,  32'h013, 32'h0,        1'b1, 32'h0000007F, 1'b0, 2, 0);
    vt[19] = mk(LD, FW,  32'h010, 32'h0,        1'b1, 32'h7FADBEEF, 1'b0, 2, 0);
    vt[20] = mk(ST, FW,  32'h7FC, 32'hA1B2C3D4, 1'b0, 32'h0,        1'b0, 2, 1);
    vt[21] = mk(ST, FW,  32'h000, 32'h55667788, 1'b0, 32'h0,        1'b0, 2, 1);
`ifdef LSU_MISALIGN_EN
    vt[22] = mk(LD, FW,  32'h7FE, 32'h0,        1'b1, 32'h7788A1B2, 1'b0, 3, 0);
    vt[23] = mk(ST, FH,  32'h7FF, 32'h1234BEEF, 1'b0, 32'h0,        1'b0, 5, 2);
    vt[24] = mk(LD, FW,  32'h7FC, 32'h0,        1'b1, 32'hEFB2C3D4, 1'b0, 2, 0);
    vt[25] = mk(LD, FW,  32'h000, 32'h0,        1'b1, 32'h556677BE, 1'b0, 2, 0);
    vt[27] = mk(LD, FHU, 32'h7FE, 32'h0,        1'b1, 32'h0000EFB2, 1'b0, 2, 0);
`else
    vt[22] = mk(LD, FW,  32'h7FE, 32'h0,        1'b1, 32'h0,        1'b1, 1, 0);
    vt[23] = mk(ST, FH,  32'h7FF, 32'h1234BEEF, 1'b1, 32'h0,        1'b1, 1, 0);
    vt[24] = mk(LD, FW,  32'h7FC, 32'h0,        1'b1, 32'hA1B2C3D4, 1'b0, 2, 0);
    vt[25] = mk(LD, FW,  32'h000, 32'h0,        1'b1, 32'h55667788, 1'b0, 2, 0);
    vt[27] = mk(LD, FHU, 32'h7FE, 32'h0,        1'b1, 32'h0000A1B2, 1'b0, 2, 0);
`endif
    vt[26] = mk(LD, FW,  32'hFFFFF010, 32'h0,   1'b1, 32'h7FADBEEF, 1'b0, 2, 0);

    // Reset state.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready",  {31'b0, o_ready},      32'd1);
    chk("rst_done",   {31'b0, o_done},       32'd0);
    chk("rst_rdata",  o_rdata,               32'd0);
    chk("rst_misal",  {31'b0, o_misaligned}, 32'd0);
    chk("rst_wren",   {31'b0, o_mem_wren},   32'd0);
    chk("rst_maddr",  {23'b0, o_mem_addr},   32'd0);
    chk("rst_funct3", {29'b0, o_mem_funct3}, 32'd2);
    i_rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, mis, lat, nwr);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_misal", i), {31'b0, mis}, {31'b0, vt[i].mis});
      chk($sformatf("v%0d_writes", i), nwr, vt[i].nwr);
      if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
    end

    // LW at the last half-word: word addresses seen on the dmem port.
    @(negedge i_clk);
    start = wr_cnt;
    i_req = 1'b1; i_we = LD; i_funct3 = FW; i_addr = 32'h7FE; i_wdata = 32'h0;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    @(negedge i_clk);
`ifdef LSU_MISALIGN_EN
    chk("wrap_rd0_addr", {23'b0, o_mem_addr}, 32'h1FF);
    @(negedge i_clk);
    chk("wrap_rd1_addr", {23'b0, o_mem_addr}, 32'h000);
    @(negedge i_clk);
    chk("wrap_done",     {31'b0, o_done}, 32'd1);
    chk("wrap_rdata",    o_rdata, 32'h77BEEFB2);
`else
    chk("wrap_done",     {31'b0, o_done}, 32'd1);
    chk("wrap_misal",    {31'b0, o_misaligned}, 32'd1);
    chk("wrap_rdata",    o_rdata, 32'h0);
`endif
    chk("wrap_no_write", wr_cnt - start, 32'd0);

    // Request held high while busy, with different data: must be ignored.
    @(negedge i_clk);
    start = wr_cnt;
    i_req = 1'b1; i_we = LD; i_funct3 = FW; i_addr = 32'h020; i_wdata = 32'h0;
    @(posedge i_clk);
    #1;
    i_we = ST; i_funct3 = FW; i_addr = 32'h020; i_wdata = 32'hFFFFFFFF;
    blat = 0;
    got  = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      blat++;
      if (o_done) got = 1'b1;
    end
    i_req = 1'b0;
    chk("busy_done_seen", {31'b0, got}, 32'd1);
    chk("busy_latency",   blat, 32'd2);
    chk("busy_rdata",     o_rdata, 32'h1122AA44);
    @(negedge i_clk);
    chk("busy_done_pulse", {31'b0, o_done}, 32'd0);
    chk("busy_no_write",   wr_cnt - start, 32'd0);
    do_req(LD, FW, 32'h020, 32'h0, rd, mis, lat, nwr);
    chk("busy_after_rdata", rd, 32'h1122AA44);

    // Reset asserted during WR0 of a byte store.
    @(negedge i_clk);
    i_req = 1'b1; i_we = ST; i_funct3 = FB; i_addr = 32'h022; i_wdata = 32'h0000005A;
    @(posedge i_clk);
    #1 i_req = 1'b0;
    @(negedge i_clk);
    chk("rstwr_rd0_wren", {31'b0, o_mem_wren}, 32'd0);
    chk("rstwr_rd0_addr", {23'b0, o_mem_addr}, 32'h008);
    @(posedge i_clk);
    #1;
    chk("rstwr_wr0_wren",  {31'b0, o_mem_wren}, 32'd1);
    chk("rstwr_wr0_wdata", o_mem_wdata, 32'h115AAA44);
    start   = wr_cnt;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("rstwr_gated_wren", {31'b0, o_mem_wren}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("rstwr_ready",    {31'b0, o_ready}, 32'd1);
    chk("rstwr_done",     {31'b0, o_done}, 32'd0);
    chk("rstwr_no_write", wr_cnt - start, 32'd0);
    do_req(LD, FW, 32'h020, 32'h0, rd, mis, lat, nwr);
    chk("rstwr_mem_kept", rd, 32'h1122AA44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
